fifo_pack_reader: RTL and testbench
===================================

Name: fifo_pack_reader

Overview:
Consumer-side engine for the syncfifo read port. It pops DT_WIDTH-bit entries and packs PACK consecutive entries into one wide word, which it presents on a valid/ready output stream. It sits between the FIFO read port (rd_en, rd_dt, f_empty) and a downstream wide-datapath sink. A flush input emits a partially filled word.

Parameters:
DT_WIDTH, 8, width of one FIFO entry (rd_dt)
PACK, 2, entries packed per output word; legal range 1..16
CNT_WIDTH, $clog2(PACK+1), width of out_cnt
WCNT_WIDTH, 16, width of words_sent counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
f_empty  input  1  FIFO empty flag
rd_dt  input  DT_WIDTH  FIFO read data; valid in the same cycle as rd_en when f_empty=0
rd_en  output  1  FIFO pop request
flush  input  1  request to emit the current partial word
out_dt  output  DT_WIDTH*PACK  packed word; entry k in bits [k*DT_WIDTH +: DT_WIDTH]
out_cnt  output  CNT_WIDTH  number of valid entries in out_dt (1..PACK)
out_valid  output  1  out_dt/out_cnt valid
out_ready  input  1  sink accepts the word
words_sent  output  WCNT_WIDTH  count of accepted output words, wraps

Behaviour:
- Reset (rst=0, async):
  - state=COLLECT, idx=0, out_dt=0, out_cnt=0, out_valid=0, words_sent=0.
  - rd_en forced 0 while rst=0.
  - Reset mid-word discards the partial data.
- FIFO read timing: the read is combinational. pop = rd_en & !f_empty. rd_dt is sampled at the same rising edge on which the FIFO pointer advances.
- rd_en = (state==COLLECT) & !f_empty. Never asserted in SEND. Never asserted when f_empty=1.
- COLLECT state, per cycle:
  - On pop: out_dt lane idx <= rd_dt. If idx==PACK-1, then out_cnt<=PACK, idx<=0, state<=SEND. Otherwise idx<=idx+1.
  - On pop and flush in the same cycle: the popped entry is included. out_cnt<=idx+1, idx<=0, state<=SEND.
  - On flush without pop and idx>0: out_cnt<=idx, idx<=0, state<=SEND.
  - On flush without pop and idx==0: ignored, no empty words are ever emitted.
  - Lanes not written in a partial word read as 0. The out_dt lanes are cleared on entry to COLLECT.
- SEND state:
  - out_valid=1. out_dt and out_cnt are held stable until accepted.
  - On out_ready=1: state<=COLLECT, out_valid<=0, words_sent<=words_sent+1 (wraps at 2^WCNT_WIDTH), out_dt lanes<=0.
  - flush is ignored in SEND.
- out_valid is registered: it rises the cycle after the completing pop and falls the cycle after the accepting edge.
- Throughput: a full word takes at least PACK+1 cycles (PACK pops plus one SEND cycle). No pop overlaps SEND.
- PACK=1: every pop goes directly to SEND with out_cnt=1.
- Stall behaviour:
  - f_empty=1 in COLLECT: idx holds, nothing is popped.
  - out_ready=0 in SEND: the FIFO is not read, so backpressure propagates to the FIFO full flag.

Test Plan:
- Reset hold: rst=0 with f_empty=0 and out_ready=1 -> rd_en=0, out_valid=0, out_dt=0, words_sent=0.
- Basic pack (PACK=2): FIFO holds 0x11,0x22, out_ready=1 -> rd_en high for 2 cycles, then out_valid=1, out_dt=0x2211, out_cnt=2. After accept, words_sent=1.
- Backpressure: FIFO holds 0xA1..0xA4, out_ready=0 for 5 cycles after the first word forms -> out_dt=0xA2A1 stays stable, rd_en=0 throughout, 0xA3/0xA4 stay in the FIFO. On release, the second word is 0xA4A3 and words_sent=2.
- Flush partial: push 0x5C, then f_empty=1, then flush=1 for one cycle -> out_dt=0x005C, out_cnt=1. Flush asserted again with idx=0 -> no output.
- Flush with simultaneous pop: idx=0, pop of 0x7E in the same cycle as flush -> out_dt=0x007E, out_cnt=1. With idx=1 holding 0x10, pop of 0x20 with flush -> out_dt=0x2010, out_cnt=2.
- Async reset mid-word: after one pop of 0x33, pulse rst low between clock edges -> outputs clear immediately. The next two pops 0x44,0x55 produce 0x5544; 0x33 is lost.

Source files
------------

// File: rtl/fifo_pack_reader_if.sv
// Bundle of the FIFO read port, flush request and packed output stream.
// master = packing engine, slave = FIFO + sink + control side.
interface fifo_pack_reader_if #(
    parameter int DT_WIDTH   = 8,
    parameter int PACK       = 2,
    parameter int CNT_WIDTH  = $clog2(PACK + 1),
    parameter int WCNT_WIDTH = 16
);
    logic                         f_empty;
    logic [DT_WIDTH-1:0]          rd_dt;
    logic                         rd_en;
    logic                         flush;
    logic [DT_WIDTH*PACK-1:0]     out_dt;
    logic [CNT_WIDTH-1:0]         out_cnt;
    logic                         out_valid;
    logic                         out_ready;
    logic [WCNT_WIDTH-1:0]        words_sent;

    modport master (
        input  f_empty,
        input  rd_dt,
        input  flush,
        input  out_ready,
        output rd_en,
        output out_dt,
        output out_cnt,
        output out_valid,
        output words_sent
    );

    modport slave (
        output f_empty,
        output rd_dt,
        output flush,
        output out_ready,
        input  rd_en,
        input  out_dt,
        input  out_cnt,
        input  out_valid,
        input  words_sent
    );
endinterface

// File: rtl/fifo_pack_reader.sv
// Pops FIFO entries and packs PACK of them (or fewer on flush) into one wide word.
// Latency: out_valid rises the cycle after the completing pop.
// Backpressure: no pops while a word waits in SEND, so a stalled sink fills the FIFO.
module fifo_pack_reader #(
    parameter int DT_WIDTH   = 8,
    parameter int PACK       = 2,
    parameter int CNT_WIDTH  = $clog2(PACK + 1),
    parameter int WCNT_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    fifo_pack_reader_if.master  bus
);
    localparam int IDX_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int OUT_W = DT_WIDTH * PACK;

    typedef enum logic {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [OUT_W-1:0]        out_dt_q, out_dt_d;
    logic [CNT_WIDTH-1:0]    out_cnt_q, out_cnt_d;
    logic [WCNT_WIDTH-1:0]   words_sent_q, words_sent_d;

    logic pop;
    logic last_lane;
    logic rd_en;

    assign pop       = rd_en & ~bus.f_empty;
    assign last_lane = (idx_q == IDX_W'(PACK - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= COLLECT;
            idx_q        <= '0;
            out_dt_q     <= '0;
            out_cnt_q    <= '0;
            words_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            out_dt_q     <= out_dt_d;
            out_cnt_q    <= out_cnt_d;
            words_sent_q <= words_sent_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: begin
                if (pop && (last_lane || bus.flush)) begin
                    state_d = SEND;
                end else if (!pop && bus.flush && (idx_q != '0)) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Datapath next values
    always_comb begin
        idx_d        = idx_q;
        out_dt_d     = out_dt_q;
        out_cnt_d    = out_cnt_q;
        words_sent_d = words_sent_q;
        case (state_q)
            COLLECT: begin
                if (pop) begin
                    out_dt_d[idx_q*DT_WIDTH +: DT_WIDTH] = bus.rd_dt;
                    if (last_lane) begin
                        out_cnt_d = CNT_WIDTH'(PACK);
                        idx_d     = '0;
                    end else if (bus.flush) begin
                        // The popped entry still belongs to the flushed word.
                        out_cnt_d = CNT_WIDTH'(idx_q) + CNT_WIDTH'(1);
                        idx_d     = '0;
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                    end
                end else if (bus.flush && (idx_q != '0)) begin
                    out_cnt_d = CNT_WIDTH'(idx_q);
                    idx_d     = '0;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    // Unwritten lanes of the next partial word must read as zero.
                    out_dt_d     = '0;
                    words_sent_d = words_sent_q + WCNT_WIDTH'(1);
                end
            end
            default: begin
                idx_d = '0;
            end
        endcase
    end

    // Outputs; rd_en is gated by reset so nothing is popped while held in reset
    always_comb begin
        rd_en          = rst & (state_q == COLLECT) & ~bus.f_empty;
        bus.rd_en      = rd_en;
        bus.out_valid  = (state_q == SEND);
        bus.out_dt     = out_dt_q;
        bus.out_cnt    = out_cnt_q;
        bus.words_sent = words_sent_q;
    end

    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst)
        bus.f_empty |-> !bus.rd_en);

    a_no_pop_in_send: assert property (@(posedge clk) disable iff (!rst)
        bus.out_valid |-> !bus.rd_en);

    a_hold_until_accept: assert property (@(posedge clk) disable iff (!rst)
        (bus.out_valid && !bus.out_ready) |=>
            (bus.out_valid && $stable(bus.out_dt) && $stable(bus.out_cnt)));

    a_cnt_legal: assert property (@(posedge clk) disable iff (!rst)
        bus.out_valid |-> ((bus.out_cnt != '0) && (bus.out_cnt <= CNT_WIDTH'(PACK))));
endmodule

// File: tb/tb_fifo_pack_reader.sv
// Directed bench for fifo_pack_reader with PACK=2, DT_WIDTH=8 and a small FIFO model.
module tb_fifo_pack_reader;
    localparam int DT   = 8;
    localparam int PACK = 2;
    localparam int CW   = 2;
    localparam int WW   = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_pack_reader_if #(.DT_WIDTH(DT), .PACK(PACK), .CNT_WIDTH(CW), .WCNT_WIDTH(WW)) bus ();

    fifo_pack_reader #(.DT_WIDTH(DT), .PACK(PACK), .CNT_WIDTH(CW), .WCNT_WIDTH(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // FIFO model: hold_empty hides stored data, force_ne shows a non-empty FIFO
    logic [7:0] mem [16];
    logic [7:0] wr_ptr     = 8'd0;
    logic [7:0] rd_ptr     = 8'd0;
    logic       hold_empty = 1'b0;
    logic       force_ne   = 1'b0;

    assign bus.f_empty = hold_empty || (!force_ne && (wr_ptr == rd_ptr));
    assign bus.rd_dt   = mem[rd_ptr[3:0]];

    always @(posedge clk) begin
        if (bus.rd_en && !bus.f_empty) begin
            #1;
            rd_ptr <= rd_ptr + 8'd1;
        end
    end

    int checks    = 0;
    int failures  = 0;
    int words_exp = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[3:0]] = d;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: out_valid=0 after 20 cycles, expected 1", nm);
        end
    endtask

    task automatic accept(input string nm);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        words_exp++;
        chk({nm, "_words"}, 32'(bus.words_sent), 32'(words_exp));
        chk({nm, "_vld_fall"}, 32'(bus.out_valid), 32'd0);
        chk({nm, "_dt_clr"}, 32'(bus.out_dt), 32'd0);
    endtask

    typedef struct {
        int         n;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       do_flush;
        logic [15:0] exp_dt;
        logic [1:0]  exp_cnt;
    } vec_t;

    vec_t tbl [5];

    initial begin
        tbl[0] = '{n: 2, d0: 8'h11, d1: 8'h22, do_flush: 1'b0, exp_dt: 16'h2211, exp_cnt: 2'd2};
        tbl[1] = '{n: 2, d0: 8'hFF, d1: 8'h00, do_flush: 1'b0, exp_dt: 16'h00FF, exp_cnt: 2'd2};
        tbl[2] = '{n: 1, d0: 8'h5C, d1: 8'h00, do_flush: 1'b1, exp_dt: 16'h005C, exp_cnt: 2'd1};
        tbl[3] = '{n: 1, d0: 8'hA5, d1: 8'h00, do_flush: 1'b1, exp_dt: 16'h00A5, exp_cnt: 2'd1};
        tbl[4] = '{n: 2, d0: 8'h01, d1: 8'h80, do_flush: 1'b0, exp_dt: 16'h8001, exp_cnt: 2'd2};

        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        force_ne      = 1'b1;

        // Reset hold with a non-empty FIFO and a ready sink
        repeat (3) @(negedge clk);
        chk("rst_rd_en", 32'(bus.rd_en), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_dt", 32'(bus.out_dt), 32'd0);
        chk("rst_out_cnt", 32'(bus.out_cnt), 32'd0);
        chk("rst_words", 32'(bus.words_sent), 32'd0);
        force_ne      = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;

        // Basic pack with a ready sink
        @(negedge clk);
        push(8'h11);
        push(8'h22);
        bus.out_ready = 1'b1;
        #1;
        chk("pack_rd_en_c0", 32'(bus.rd_en), 32'd1);
        @(negedge clk);
        chk("pack_rd_en_c1", 32'(bus.rd_en), 32'd1);
        chk("pack_vld_c1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("pack_vld", 32'(bus.out_valid), 32'd1);
        chk("pack_rd_en_send", 32'(bus.rd_en), 32'd0);
        chk("pack_dt", 32'(bus.out_dt), 32'h2211);
        chk("pack_cnt", 32'(bus.out_cnt), 32'd2);
        words_exp++;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("pack_vld_fall", 32'(bus.out_valid), 32'd0);
        chk("pack_words", 32'(bus.words_sent), 32'(words_exp));

        // Table-driven words
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            push(tbl[i].d0);
            if (tbl[i].n == 2) push(tbl[i].d1);
            if (tbl[i].do_flush) begin
                repeat (2) @(negedge clk);
                chk($sformatf("tbl%0d_no_vld_before_flush", i), 32'(bus.out_valid), 32'd0);
                bus.flush = 1'b1;
                @(negedge clk);
                bus.flush = 1'b0;
            end
            wait_valid($sformatf("tbl%0d_wait", i));
            chk($sformatf("tbl%0d_dt", i), 32'(bus.out_dt), 32'(tbl[i].exp_dt));
            chk($sformatf("tbl%0d_cnt", i), 32'(bus.out_cnt), 32'(tbl[i].exp_cnt));
            accept($sformatf("tbl%0d", i));
        end

        // Backpressure: word held, FIFO untouched while sink stalls
        @(negedge clk);
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        push(8'hA4);
        wait_valid("bp_wait1");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold_dt%0d", i), 32'(bus.out_dt), 32'hA2A1);
            chk($sformatf("bp_hold_rd_en%0d", i), 32'(bus.rd_en), 32'd0);
            @(negedge clk);
        end
        chk("bp_fifo_level", 32'(wr_ptr - rd_ptr), 32'd2);
        accept("bp1");
        wait_valid("bp_wait2");
        chk("bp_dt2", 32'(bus.out_dt), 32'hA4A3);
        accept("bp2");

        // Flush with nothing collected emits nothing
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("idle_flush_vld%0d", i), 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end
        chk("idle_flush_words", 32'(bus.words_sent), 32'(words_exp));

        // Flush together with a pop at idx=0
        hold_empty = 1'b1;
        push(8'h7E);
        @(negedge clk);
        hold_empty = 1'b0;
        bus.flush  = 1'b1;
        @(negedge clk);
        bus.flush  = 1'b0;
        chk("fp0_vld", 32'(bus.out_valid), 32'd1);
        chk("fp0_dt", 32'(bus.out_dt), 32'h007E);
        chk("fp0_cnt", 32'(bus.out_cnt), 32'd1);
        accept("fp0");

        // Flush together with a pop at idx=1
        @(negedge clk);
        push(8'h10);
        @(negedge clk);
        hold_empty = 1'b1;
        push(8'h20);
        @(negedge clk);
        chk("fp1_no_vld", 32'(bus.out_valid), 32'd0);
        hold_empty = 1'b0;
        bus.flush  = 1'b1;
        @(negedge clk);
        bus.flush  = 1'b0;
        chk("fp1_dt", 32'(bus.out_dt), 32'h2010);
        chk("fp1_cnt", 32'(bus.out_cnt), 32'd2);
        accept("fp1");

        // Async reset between edges discards a half-built word
        @(negedge clk);
        push(8'h33);
        @(negedge clk);
        chk("ar_partial_dt", 32'(bus.out_dt), 32'h0033);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_dt_clr", 32'(bus.out_dt), 32'd0);
        chk("ar_vld", 32'(bus.out_valid), 32'd0);
        chk("ar_words", 32'(bus.words_sent), 32'd0);
        chk("ar_rd_en", 32'(bus.rd_en), 32'd0);
        words_exp = 0;
        #1;
        rst = 1'b1;
        @(negedge clk);
        push(8'h44);
        push(8'h55);
        wait_valid("ar_wait");
        chk("ar_dt", 32'(bus.out_dt), 32'h5544);
        chk("ar_cnt", 32'(bus.out_cnt), 32'd2);
        accept("ar");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
